// File: rtl/dll_arb.sv
// dll_arb: round-robin front end serialising per-id list requests into one engine command at a time.
// Build option DLL_ARB_ERR_RSP_EN: illegal requests get an immediate error ack instead of being held off.
module dll_arb #(
  parameter  int ID_N  = 4,
  parameter  int PTR_N = 256,
  parameter  int W     = 32,
  localparam int IW    = (ID_N > 1) ? $clog2(ID_N) : 1,
  localparam int CW    = 8,
  localparam int TW    = $clog2(PTR_N)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ID_N-1:0]   i_req_valid,
  input  logic [2*ID_N-1:0] i_req_op,
  input  logic [W*ID_N-1:0] i_req_data,
  output logic [ID_N-1:0]   o_req_ready,
  output logic              o_cmd_valid,
  output logic [1:0]        o_cmd_op,
  output logic [IW-1:0]     o_cmd_id,
  output logic [W-1:0]      o_cmd_data,
  input  logic              i_cmd_ready,
  input  logic              i_rsp_valid,
  input  logic [W-1:0]      i_rsp_data,
  output logic [ID_N-1:0]   o_ack_valid,
  output logic [W-1:0]      o_ack_data,
  output logic              o_ack_err,
  output logic [ID_N-1:0]   o_empty,
  output logic              o_full,
  output logic              o_busy
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;

  localparam logic [TW-1:0] FULL_LVL = TW'(PTR_N - 1);

  state_t                  r_state;
  logic [IW-1:0]           r_rr_ptr;
  logic [1:0]              r_op;
  logic [IW-1:0]           r_id;
  logic [W-1:0]            r_data;
  logic                    r_cmd_valid;
  logic [ID_N-1:0]         r_ack_valid;
  logic [W-1:0]            r_ack_data;
  logic                    r_ack_err;
  logic                    r_busy;
  logic [ID_N-1:0][CW-1:0] r_cnt;
  logic [TW-1:0]           r_total;
  logic [ID_N-1:0]         r_empty;
  logic                    r_full;

  logic [ID_N-1:0]         w_legal;
  logic [ID_N-1:0]         w_elig;
  logic                    w_gnt_any;
  logic [IW-1:0]           w_gnt_id;
  logic [1:0]              w_gnt_op;
  logic [W-1:0]            w_gnt_data;
  logic                    w_err_gnt;
  logic                    w_rsp_fire;
  logic [ID_N-1:0][CW-1:0] w_cnt_nxt;
  logic [TW-1:0]           w_total_nxt;
  logic [ID_N-1:0]         w_empty_nxt;
  logic                    w_full_nxt;

  function automatic logic [ID_N-1:0] f_onehot(input logic [IW-1:0] id);
    return ID_N'(1) << id;
  endfunction

  // A pop needs a non-empty list, a push needs free capacity
  always_comb begin
    w_legal = '0;
    for (int i = 0; i < ID_N; i++) begin
      if (i_req_op[2*i+1]) begin
        w_legal[i] = ~r_full;
      end else begin
        w_legal[i] = ~r_empty[i];
      end
    end
  end

`ifdef DLL_ARB_ERR_RSP_EN
  assign w_elig    = i_req_valid;
  assign w_err_gnt = ~w_legal[w_gnt_id];
`else
  assign w_elig    = i_req_valid & w_legal;
  assign w_err_gnt = 1'b0;
`endif

  // Round-robin pick: first eligible id at or after the pointer, wrapping
  always_comb begin
    int idx;
    idx        = 0;
    w_gnt_any  = 1'b0;
    w_gnt_id   = '0;
    w_gnt_op   = 2'b00;
    w_gnt_data = '0;
    for (int k = 0; k < ID_N; k++) begin
      idx = int'(r_rr_ptr) + k;
      idx = (idx >= ID_N) ? idx - ID_N : idx;
      if (!w_gnt_any && w_elig[idx]) begin
        w_gnt_any  = 1'b1;
        w_gnt_id   = IW'(idx);
        w_gnt_op   = i_req_op[2*idx +: 2];
        w_gnt_data = i_req_data[W*idx +: W];
      end else begin
        w_gnt_any  = w_gnt_any;
      end
    end
  end

  assign w_rsp_fire = (r_state == S_WAIT) && i_rsp_valid;

  // Occupancy moves only when the engine completes; guards keep counters in range
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_total_nxt = r_total;
    w_empty_nxt = '0;
    if (w_rsp_fire && r_op[1] && (r_total != FULL_LVL)) begin
      w_cnt_nxt[r_id] = r_cnt[r_id] + CW'(1);
      w_total_nxt     = r_total + TW'(1);
    end else if (w_rsp_fire && !r_op[1] && !r_empty[r_id]) begin
      w_cnt_nxt[r_id] = r_cnt[r_id] - CW'(1);
      w_total_nxt     = r_total - TW'(1);
    end else begin
      w_total_nxt     = r_total;
    end
    for (int i = 0; i < ID_N; i++) begin
      w_empty_nxt[i] = (w_cnt_nxt[i] == CW'(0));
    end
  end

  assign w_full_nxt = (w_total_nxt == FULL_LVL);

  // Arbitration FSM, command/ack registers and occupancy bookkeeping
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_op        <= 2'b00;
      r_id        <= '0;
      r_data      <= '0;
      r_cmd_valid <= 1'b0;
      r_ack_valid <= '0;
      r_ack_data  <= '0;
      r_ack_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_cnt       <= '0;
      r_total     <= '0;
      r_empty     <= '1;
      r_full      <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_total     <= w_total_nxt;
      r_empty     <= w_empty_nxt;
      r_full      <= w_full_nxt;
      r_ack_valid <= '0;
      r_ack_data  <= '0;
      r_ack_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_any) begin
            r_rr_ptr <= (w_gnt_id == IW'(ID_N - 1)) ? '0 : w_gnt_id + IW'(1);
            if (w_err_gnt) begin
              r_ack_valid <= f_onehot(w_gnt_id);
              r_ack_err   <= 1'b1;
            end else begin
              r_op        <= w_gnt_op;
              r_id        <= w_gnt_id;
              r_data      <= w_gnt_data;
              r_cmd_valid <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= S_ISSUE;
            end
          end else begin
            r_cmd_valid <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (i_cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_state     <= S_WAIT;
          end else begin
            r_cmd_valid <= 1'b1;
          end
        end
        S_WAIT: begin
          // Ack carries whatever the engine returned; meaningful for pops
          if (w_rsp_fire) begin
            r_ack_valid <= f_onehot(r_id);
            r_ack_data  <= i_rsp_data;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_busy      <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready = (!i_rst && (r_state == S_IDLE) && w_gnt_any) ? f_onehot(w_gnt_id) : '0;
  assign o_cmd_valid = r_cmd_valid;
  assign o_cmd_op    = r_op;
  assign o_cmd_id    = r_id;
  assign o_cmd_data  = r_data;
  assign o_ack_valid = r_ack_valid;
  assign o_ack_data  = r_ack_data;
  assign o_ack_err   = r_ack_err;
  assign o_empty     = r_empty;
  assign o_full      = r_full;
  assign o_busy      = r_busy;

endmodule

// File: doc/dll_arb.md
DLL_ARB -- requirements
Module: dll_arb

Interface
REQ-001 Parameter ID_N, default 4, number of requesters, one list id per requester.
REQ-002 Parameter PTR_N, default 256, engine pointer space; pointer 0 reserved, so capacity is PTR_N-1 = 255 entries.
REQ-003 Parameter W, default 32, data word width.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  ID_N  request pending, one bit per requester.
REQ-007 req_op  in  2*ID_N  per-requester op: 00 pop front, 01 pop back, 10 push front, 11 push back.
REQ-008 req_data  in  W*ID_N  per-requester push data.
REQ-009 req_ready  out  ID_N  one-hot acceptance pulse.
REQ-010 cmd_valid  out  1  command to the list engine.
REQ-011 cmd_op, cmd_id, cmd_data  out  2, $clog2(ID_N), W  command fields.
REQ-012 cmd_ready  in  1  engine accepts the command.
REQ-013 rsp_valid, rsp_data  in  1, W  engine completion and pop data.
REQ-014 ack_valid  out  ID_N  one-hot completion pulse to the requester.
REQ-015 ack_data, ack_err  out  W, 1  pop data; illegal-op flag.
REQ-016 empty  out  ID_N  per-id list empty; full  out  1  total occupancy is 255; busy  out  1  FSM not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE and WAIT; at most one command is outstanding at a time.
REQ-018 In IDLE with any eligible request, the block SHALL grant one requester by round-robin starting at the id after the last grant, pulse req_ready for it, latch op/id/data, and go to ISSUE.
REQ-019 In ISSUE, cmd_valid SHALL be 1 with fields stable until the cycle in which cmd_ready=1, then the FSM goes to WAIT.
REQ-020 In WAIT, rsp_valid=1 SHALL update the counts and move the FSM to IDLE; ack_valid, ack_data and ack_err=0 SHALL pulse exactly one cycle later.
REQ-021 Per-id counts SHALL be ID_N x 8 bits, with total count = sum; pushes increment and pops decrement, on rsp_valid only.
REQ-022 A pop on an empty id or a push while full is illegal; its handling is defined by REQ-027/REQ-028.
REQ-023 rsp_valid outside WAIT SHALL be ignored.
REQ-024 Minimum turnaround SHALL be: grant at cycle 0, cmd_valid at cycle 1, rsp_valid at cycle 2 earliest, ack at cycle 3, next grant at cycle 3.
REQ-025 Non-granted requesters SHALL hold req_valid/op/data; the block does not capture them.

Reset
REQ-026 While rst=1: FSM=IDLE, counts=0, RR pointer=0, req_ready=0, cmd_valid=0, ack_valid=0, ack_err=0, ack_data=0, empty=all 1s, full=0, busy=0; an in-flight command is abandoned and its later rsp_valid is ignored.

Configuration
REQ-027 With DLL_ARB_ERR_RSP_EN defined, illegal requests SHALL be granted in IDLE with no command issued; ack_valid and ack_err=1 pulse the next cycle and the FSM stays in IDLE.
REQ-028 Without DLL_ARB_ERR_RSP_EN, illegal requests SHALL be excluded from arbitration (req_ready stays 0) until they become legal; ack_err is tied 0.

Verification
REQ-029 Push-back from id 0 with data 0xA5, cmd_ready=1, rsp_valid at cycle 2 -> cmd_op=11, cmd_id=0, ack_valid=0001 at cycle 3, empty[0]=0.
REQ-030 All four ids request pushes continuously; engine responds immediately -> grants are 0,1,2,3,0, each cycle-spaced by 3 cycles.
REQ-031 Pop-front on empty id 2 -> with the macro: ack_valid=0100, ack_err=1 one cycle after the grant, no cmd_valid; without the macro: req_ready[2] stays 0.
REQ-032 255 pushes, then a 256th push -> full=1 after the 255th ack; the 256th is handled per REQ-027/REQ-028; after one pop, full=0.
REQ-033 cmd_ready held 0 for 5 cycles -> cmd_valid and fields stable throughout; busy=1.
REQ-034 rst asserted in WAIT, then stale rsp_valid -> all outputs return to reset values; the stale rsp_valid causes no ack and no count change.
